// File: rtl/rotl_pipe.sv
// rotl_pipe: pipelined full-width left rotate, one log-shifter stage per
// shift-amount bit, with a valid/ready handshake and whole-pipeline stall.
module rotl_pipe #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned SHIFT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] shift_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a_out
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SW = SHIFT_WIDTH;

    logic stall;

    // The pipeline only halts when a finished result is waiting on downstream.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int unsigned AMT = 32'(1) << k;

        logic [DW-1:0] src_data;
        logic [SW-1:0] src_sh;
        logic          src_v;
        logic [DW-1:0] rot_data;

        logic [DW-1:0] data_q;
        logic [SW-1:0] sh_q;
        logic          v_q;

        // Stage input: the operand port for the first stage, the previous stage otherwise.
        if (k == 0) begin : g_first
            assign src_data = a_in;
            assign src_sh   = shift_in[SW-1:0];
            assign src_v    = in_valid & in_ready;
        end else begin : g_next
            assign src_data = g_stage[k-1].data_q;
            assign src_sh   = g_stage[k-1].sh_q;
            assign src_v    = g_stage[k-1].v_q;
        end

        // Conditional rotate by 2**k; high bits wrap into the low end.
        assign rot_data = src_sh[k] ? {src_data[DW-1-AMT:0], src_data[DW-1:DW-AMT]}
                                    : src_data;

        // Stage register: holds on stall, otherwise loads (bubbles included).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                sh_q   <= '0;
                v_q    <= 1'b0;
            end else if (!stall) begin
                data_q <= rot_data;
                sh_q   <= src_sh;
                v_q    <= src_v;
            end
        end
    end

    assign a_out     = g_stage[SW-1].data_q;
    assign out_valid = g_stage[SW-1].v_q;

    // Upper shift bits and the final residual shift carry no information.
    logic unused_bits;
    assign unused_bits = ^{shift_in[DW-1:SW], g_stage[SW-1].sh_q};

endmodule

// File: tb/tb_rotl_pipe.sv
// Directed bench for rotl_pipe: latency, ordering, wrap, bubbles,
// backpressure and asynchronous reset with work in flight.
module tb_rotl_pipe;

    localparam int unsigned DW = 256;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] shift_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] a_out;

    int n_cmp  = 0;
    int n_fail = 0;

    rotl_pipe #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out)
    );

    always #5 clk = ~clk;

    // Reference rotate written as a double-width shift, independent of the stage structure.
    function automatic logic [DW-1:0] rotl_model(input logic [DW-1:0] a, input logic [DW-1:0] s);
        logic [2*DW-1:0] w;
        int unsigned     n;
        n = 32'(s[SW-1:0]);
        w = {a, a} << n;
        return w[2*DW-1:DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; shift_in = '0; out_ready = 1'b1;
        #3;
        n_cmp++; if (a_out !== '0) begin n_fail++; $display("FAIL reset_a_out got=%h exp=0", a_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step(); step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; a_in = 256'd1; shift_in = '0; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_accept_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; a_in = '0;
        for (int j = 0; j <= 8; j++) begin
            n_cmp++;
            if (out_valid !== (j == 7)) begin
                n_fail++; $display("FAIL lat_out_valid cycle=%0d got=%b exp=%b", j, out_valid, (j == 7));
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready cycle=%0d got=%b exp=1", j, in_ready); end
            if (j == 7) begin
                n_cmp++; if (a_out !== 256'd1) begin n_fail++; $display("FAIL lat_a_out got=%h exp=1", a_out); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] sh [3];
        logic [DW-1:0] ex [3];
        sh[0] = 256'd1;   ex[0] = 256'd2;
        sh[1] = 256'd255; ex[1] = {1'b1, 255'd0};
        sh[2] = 256'd128; ex[2] = {127'd0, 1'b1, 128'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_in = 256'd1; shift_in = sh[i];
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, out_valid); end
            n_cmp++; if (a_out !== ex[i]) begin n_fail++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, a_out, ex[i]); end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] av [3];
        logic [DW-1:0] sh [3];
        logic [DW-1:0] ex [3];
        av[0] = {8'hFF, 248'd0};            sh[0] = 256'd8;     ex[0] = 256'hFF;
        av[1] = {8'hA5, 240'd0, 8'h3C};     sh[1] = 256'h104;   ex[1] = {8'h50, 236'd0, 12'h3CA};
        av[2] = {8'hA5, 240'd0, 8'h3C};     sh[2] = 256'd4;     ex[2] = {8'h50, 236'd0, 12'h3CA};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_in = av[i]; shift_in = sh[i];
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid idx=%0d got=%b exp=1", i, out_valid); end
            n_cmp++; if (a_out !== ex[i]) begin n_fail++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, a_out, ex[i]); end
            step();
        end
    endtask

    task automatic test_bubbles();
        logic          pat [4];
        logic [DW-1:0] ex  [4];
        pat[0] = 1'b1; ex[0] = 256'd8;
        pat[1] = 1'b0; ex[1] = '0;
        pat[2] = 1'b1; ex[2] = 256'd128;
        pat[3] = 1'b0; ex[3] = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i]; a_in = 256'd1; shift_in = (i == 0) ? 256'd3 : 256'd7;
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_early_valid cycle=%0d got=%b exp=0", j, out_valid); end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== pat[i]) begin n_fail++; $display("FAIL bub_valid idx=%0d got=%b exp=%b", i, out_valid, pat[i]); end
            if (pat[i]) begin
                n_cmp++; if (a_out !== ex[i]) begin n_fail++; $display("FAIL bub_data idx=%0d got=%h exp=%h", i, a_out, ex[i]); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q[$];
        logic [DW-1:0] cur_a, cur_s, exp_v, prev_out;
        logic          have, prev_stall;
        int            sent, got, cyc;
        sent = 0; got = 0; cyc = 0; have = 1'b0; prev_stall = 1'b0; prev_out = '0;
        cur_a = '0; cur_s = '0;
        while ((sent < 20 || got < 20) && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!have && sent < 20) begin
                have = ($urandom_range(0, 3) != 0);
                if (have) begin
                    cur_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    cur_s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
            end
            in_valid = have; a_in = cur_a; shift_in = cur_s;
            #1;
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b ov=%b or=%b", cyc, in_ready, out_valid, out_ready);
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || a_out !== prev_out) begin
                    n_fail++; $display("FAIL bp_hold cycle=%0d got=%b/%h exp=1/%h", cyc, out_valid, a_out, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_result cycle=%0d got=%h exp=none", cyc, a_out);
                end else begin
                    exp_v = q.pop_front();
                    if (a_out !== exp_v) begin n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", got, a_out, exp_v); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(rotl_model(cur_a, cur_s));
                sent++;
                have = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = a_out;
            step();
            cyc++;
        end
        n_cmp++; if (cyc >= 2000) begin n_fail++; $display("FAIL bp_timeout sent=%0d got=%0d exp=20/20", sent, got); end
        n_cmp++; if (got != 20 || q.size() != 0) begin n_fail++; $display("FAIL bp_count got=%0d left=%0d exp=20/0", got, q.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid cycle=%0d got=%b exp=0", j, out_valid); end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a_in = 256'd1; shift_in = DW'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (out_valid !== 1'b1 || a_out !== 256'd1) begin n_fail++; $display("FAIL mid_pre got=%b/%h exp=1/1", out_valid, a_out); end
        step(); step();
        n_cmp++; if (out_valid !== 1'b1 || a_out !== 256'd1) begin n_fail++; $display("FAIL mid_stall_hold got=%b/%h exp=1/1", out_valid, a_out); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_stall_ready got=%b exp=0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (a_out !== '0) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=0", a_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid cycle=%0d got=%b exp=0", j, out_valid); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap();
        test_bubbles();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
